// File: rtl/hazard_if.sv
// Decode-info / hazard-control bundle between the pipeline instruction coder and hazard_ctrl.
// The coder side uses master; hazard_ctrl uses slave.
interface hazard_if;
    logic       tuse_rs0;
    logic       tuse_rs1;
    logic       tuse_rt0;
    logic       tuse_rt1;
    logic       tuse_rt2;
    logic [4:0] a1_d;
    logic [4:0] a2_d;
    logic [4:0] a1_e;
    logic [4:0] a2_e;
    logic [4:0] a3_e;
    logic [4:0] a2_m;
    logic [4:0] a3_m;
    logic [4:0] a3_w;
    logic [1:0] res_e;
    logic [1:0] res_m;
    logic [1:0] res_w;
    logic       md_start_e;
    logic       md_is_div_e;
    logic       md_use_d;

    logic        stall;
    logic [1:0]  fwd_rs_d;
    logic [1:0]  fwd_rt_d;
    logic [1:0]  fwd_rs_e;
    logic [1:0]  fwd_rt_e;
    logic        fwd_rt_m;
    logic        md_busy;
    logic [15:0] stall_cnt;

    modport master (
        output tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2,
        output a1_d, a2_d, a1_e, a2_e, a3_e, a2_m, a3_m, a3_w,
        output res_e, res_m, res_w,
        output md_start_e, md_is_div_e, md_use_d,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m,
        input  md_busy, stall_cnt
    );

    modport slave (
        input  tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2,
        input  a1_d, a2_d, a1_e, a2_e, a3_e, a2_m, a3_m, a3_w,
        input  res_e, res_m, res_w,
        input  md_start_e, md_is_div_e, md_use_d,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m,
        output md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for the 5-stage MIPS pipeline, plus the HI/LO busy timer
// and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input logic     clk,
    input logic     reset,
    hazard_if.slave bus
);

    localparam logic [1:0] ResNone = 2'b00;
    localparam logic [1:0] ResAlu  = 2'b01;
    localparam logic [1:0] ResDm   = 2'b10;
    localparam logic [1:0] ResPc   = 2'b11;

    localparam logic [1:0] FwdReg  = 2'b00;
    localparam logic [1:0] FwdM    = 2'b01;
    localparam logic [1:0] FwdW    = 2'b10;
    localparam logic [1:0] FwdEPc  = 2'b11;

    // Register $0 is hardwired, so it never takes part in a dependency.
    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 5'd0);
    endfunction

    function automatic logic src_stall(
        input logic       used,
        input logic [1:0] tuse,
        input logic [4:0] a,
        input logic [4:0] a3_e,
        input logic [1:0] tnew_e,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m
    );
        return used && ((hit(a, a3_e) && (tnew_e > tuse)) ||
                        (hit(a, a3_m) && (tnew_m > tuse)));
    endfunction

    // A dm result sitting in M is deliberately not a forwarding source.
    function automatic logic m_fwdable(input logic [1:0] res);
        return (res == ResAlu) || (res == ResPc);
    endfunction

    function automatic logic [1:0] fwd_e_sel(
        input logic [4:0] a,
        input logic [4:0] a3_m,
        input logic [1:0] res_m,
        input logic [4:0] a3_w,
        input logic [1:0] res_w
    );
        logic [1:0] sel;
        sel = FwdReg;
        if (hit(a, a3_m) && m_fwdable(res_m)) begin
            sel = FwdM;
        end else if (hit(a, a3_w) && (res_w != ResNone)) begin
            sel = FwdW;
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_d_sel(
        input logic [4:0] a,
        input logic [4:0] a3_e,
        input logic [1:0] res_e,
        input logic [4:0] a3_m,
        input logic [1:0] res_m,
        input logic [4:0] a3_w,
        input logic [1:0] res_w
    );
        logic [1:0] sel;
        if (hit(a, a3_e) && (res_e == ResPc)) begin
            sel = FwdEPc;
        end else begin
            sel = fwd_e_sel(a, a3_m, res_m, a3_w, res_w);
        end
        return sel;
    endfunction

    logic [1:0]       tnew_e;
    logic [1:0]       tnew_m;
    logic             rs_used;
    logic [1:0]       rs_tuse;
    logic             rt_used;
    logic [1:0]       rt_tuse;
    logic             data_stall;
    logic             md_stall;
    logic             stall_w;
    logic [CNT_W-1:0] md_cnt_q;
    logic [CNT_W-1:0] md_cnt_d;
    logic [15:0]      stall_cnt_q;
    logic [15:0]      stall_cnt_d;

    always_comb begin
        tnew_e = 2'd0;
        unique case (bus.res_e)
            ResAlu:  tnew_e = 2'd1;
            ResDm:   tnew_e = 2'd2;
            default: tnew_e = 2'd0;
        endcase
        tnew_m = (bus.res_m == ResDm) ? 2'd1 : 2'd0;
    end

    always_comb begin
        rs_used = bus.tuse_rs0 | bus.tuse_rs1;
        rs_tuse = bus.tuse_rs0 ? 2'd0 : 2'd1;
        rt_used = bus.tuse_rt0 | bus.tuse_rt1 | bus.tuse_rt2;
        if (bus.tuse_rt0) begin
            rt_tuse = 2'd0;
        end else if (bus.tuse_rt1) begin
            rt_tuse = 2'd1;
        end else begin
            rt_tuse = 2'd2;
        end
    end

    always_comb begin
        data_stall = src_stall(rs_used, rs_tuse, bus.a1_d, bus.a3_e, tnew_e, bus.a3_m, tnew_m) |
                     src_stall(rt_used, rt_tuse, bus.a2_d, bus.a3_e, tnew_e, bus.a3_m, tnew_m);
        md_stall   = bus.md_use_d & ((md_cnt_q != '0) | bus.md_start_e);
        stall_w    = data_stall | md_stall;
    end

    assign bus.stall    = stall_w;
    assign bus.fwd_rs_d = fwd_d_sel(bus.a1_d, bus.a3_e, bus.res_e, bus.a3_m, bus.res_m,
                                    bus.a3_w, bus.res_w);
    assign bus.fwd_rt_d = fwd_d_sel(bus.a2_d, bus.a3_e, bus.res_e, bus.a3_m, bus.res_m,
                                    bus.a3_w, bus.res_w);
    assign bus.fwd_rs_e = fwd_e_sel(bus.a1_e, bus.a3_m, bus.res_m, bus.a3_w, bus.res_w);
    assign bus.fwd_rt_e = fwd_e_sel(bus.a2_e, bus.a3_m, bus.res_m, bus.a3_w, bus.res_w);
    assign bus.fwd_rt_m = hit(bus.a2_m, bus.a3_w) && (bus.res_w != ResNone);

    // Busy timer runs regardless of stall; a new start simply reloads it.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (bus.md_start_e) begin
            md_cnt_d = bus.md_is_div_e ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_w && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.md_busy   = (md_cnt_q != '0);
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus randomized
// stimulus against a behavioural model of the stall/forward rules.
module tb_hazard_ctrl;

    localparam int MULT = 5;
    localparam int DIV  = 10;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   md_rem;
    int   scnt;

    hazard_if hif();

    hazard_ctrl #(
        .MULT_CYC(MULT),
        .DIV_CYC (DIV),
        .CNT_W   (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic int tnew_e_of(input logic [1:0] r);
        case (r)
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int tnew_m_of(input logic [1:0] r);
        return (r == 2'b10) ? 1 : 0;
    endfunction

    function automatic int rs_tuse();
        if (hif.tuse_rs0) return 0;
        if (hif.tuse_rs1) return 1;
        return -1;
    endfunction

    function automatic int rt_tuse();
        if (hif.tuse_rt0) return 0;
        if (hif.tuse_rt1) return 1;
        if (hif.tuse_rt2) return 2;
        return -1;
    endfunction

    function automatic bit conflict(input logic [4:0] a, input int tuse);
        if (tuse < 0 || a == 5'd0) return 1'b0;
        return (a == hif.a3_e && tnew_e_of(hif.res_e) > tuse) ||
               (a == hif.a3_m && tnew_m_of(hif.res_m) > tuse);
    endfunction

    function automatic bit model_stall();
        return conflict(hif.a1_d, rs_tuse()) || conflict(hif.a2_d, rt_tuse()) ||
               (hif.md_use_d && (md_rem > 0 || hif.md_start_e));
    endfunction

    function automatic logic [1:0] model_fwd_e(input logic [4:0] a);
        if (a == 5'd0) return 2'b00;
        if (a == hif.a3_m && (hif.res_m == 2'b01 || hif.res_m == 2'b11)) return 2'b01;
        if (a == hif.a3_w && hif.res_w != 2'b00) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [1:0] model_fwd_d(input logic [4:0] a);
        if (a != 5'd0 && a == hif.a3_e && hif.res_e == 2'b11) return 2'b11;
        return model_fwd_e(a);
    endfunction

    function automatic logic model_fwd_m();
        return hif.a2_m == hif.a3_w && hif.a3_w != 5'd0 && hif.res_w != 2'b00;
    endfunction

    // Advance model state using the inputs present at the coming edge, then clock.
    task automatic step();
        bit s;
        s = model_stall();
        if (reset) begin
            md_rem = 0;
            scnt   = 0;
        end else begin
            if (hif.md_start_e) md_rem = hif.md_is_div_e ? DIV : MULT;
            else if (md_rem > 0) md_rem = md_rem - 1;
            if (s && scnt < 65535) scnt = scnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hif.tuse_rs0 = 0; hif.tuse_rs1 = 0;
        hif.tuse_rt0 = 0; hif.tuse_rt1 = 0; hif.tuse_rt2 = 0;
        hif.a1_d = 0; hif.a2_d = 0; hif.a1_e = 0; hif.a2_e = 0; hif.a3_e = 0;
        hif.a2_m = 0; hif.a3_m = 0; hif.a3_w = 0;
        hif.res_e = 0; hif.res_m = 0; hif.res_w = 0;
        hif.md_start_e = 0; hif.md_is_div_e = 0; hif.md_use_d = 0;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        checks++;
        if (hif.stall !== 1'b0) begin
            $display("FAIL reset_stall: got %b want 0", hif.stall); failures++;
        end
        checks++;
        if ({hif.fwd_rs_d, hif.fwd_rt_d, hif.fwd_rs_e, hif.fwd_rt_e, hif.fwd_rt_m} !== 9'd0) begin
            $display("FAIL reset_fwd: got %b want 0",
                     {hif.fwd_rs_d, hif.fwd_rt_d, hif.fwd_rs_e, hif.fwd_rt_e, hif.fwd_rt_m});
            failures++;
        end
        checks++;
        if (hif.md_busy !== 1'b0 || hif.stall_cnt !== 16'd0) begin
            $display("FAIL reset_state: busy=%b cnt=%0d want 0/0", hif.md_busy, hif.stall_cnt);
            failures++;
        end
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        clear_inputs();
        hif.res_e = 2'b10; hif.a3_e = 5'd1; hif.a1_d = 5'd1; hif.tuse_rs1 = 1; #1;
        checks++;
        if (hif.stall !== 1'b1) begin
            $display("FAIL load_use_e: stall=%b want 1", hif.stall); failures++;
        end
        step();
        hif.res_e = 0; hif.a3_e = 0; hif.res_m = 2'b10; hif.a3_m = 5'd1; #1;
        checks++;
        if (hif.stall !== 1'b0) begin
            $display("FAIL load_use_m: stall=%b want 0", hif.stall); failures++;
        end
        step();
        hif.res_m = 0; hif.a3_m = 0; hif.a1_d = 0; hif.tuse_rs1 = 0;
        hif.a1_e = 5'd1; hif.a3_w = 5'd1; hif.res_w = 2'b10; #1;
        checks++;
        if (hif.fwd_rs_e !== 2'b10) begin
            $display("FAIL load_use_w_fwd: fwd_rs_e=%b want 10", hif.fwd_rs_e); failures++;
        end
        checks++;
        if (hif.stall_cnt !== 16'(scnt)) begin
            $display("FAIL load_use_cnt: stall_cnt=%0d want %0d", hif.stall_cnt, scnt);
            failures++;
        end
    endtask

    task automatic test_branch_fwd();
        clear_inputs();
        hif.tuse_rs0 = 1; hif.a1_d = 5'd2; hif.res_e = 2'b01; hif.a3_e = 5'd2; #1;
        checks++;
        if (hif.stall !== 1'b1) begin
            $display("FAIL beq_alu_e: stall=%b want 1", hif.stall); failures++;
        end
        step();
        hif.res_e = 0; hif.a3_e = 0; hif.res_m = 2'b01; hif.a3_m = 5'd2; #1;
        checks++;
        if (hif.stall !== 1'b0 || hif.fwd_rs_d !== 2'b01) begin
            $display("FAIL beq_alu_m: stall=%b fwd_rs_d=%b want 0/01", hif.stall, hif.fwd_rs_d);
            failures++;
        end
        step();
    endtask

    task automatic test_jal_jr();
        clear_inputs();
        hif.res_e = 2'b11; hif.a3_e = 5'd31; hif.a1_d = 5'd31; hif.tuse_rs0 = 1;
        // Older M and W writers of $31 must lose to the newer E-stage pc8.
        hif.res_m = 2'b01; hif.a3_m = 5'd31; hif.res_w = 2'b01; hif.a3_w = 5'd31; #1;
        checks++;
        if (hif.stall !== 1'b0 || hif.fwd_rs_d !== 2'b11) begin
            $display("FAIL jal_jr: stall=%b fwd_rs_d=%b want 0/11", hif.stall, hif.fwd_rs_d);
            failures++;
        end
        step();
    endtask

    task automatic test_store_fwd();
        clear_inputs();
        hif.tuse_rt2 = 1; hif.a2_d = 5'd3; hif.res_e = 2'b10; hif.a3_e = 5'd3; #1;
        checks++;
        if (hif.stall !== 1'b0) begin
            $display("FAIL sw_after_lw: stall=%b want 0", hif.stall); failures++;
        end
        step();
        clear_inputs();
        hif.a2_m = 5'd3; hif.a3_w = 5'd3; hif.res_w = 2'b10; #1;
        checks++;
        if (hif.fwd_rt_m !== 1'b1) begin
            $display("FAIL sw_fwd_m: fwd_rt_m=%b want 1", hif.fwd_rt_m); failures++;
        end
        hif.a2_e = 5'd3; hif.res_m = 2'b10; hif.a3_m = 5'd3; #1;
        checks++;
        if (hif.fwd_rt_e !== 2'b10) begin
            $display("FAIL dm_in_m_not_fwd: fwd_rt_e=%b want 10", hif.fwd_rt_e); failures++;
        end
        step();
    endtask

    task automatic test_md_timer();
        clear_inputs();
        hif.md_start_e = 1; hif.md_is_div_e = 1; hif.md_use_d = 1; #1;
        checks++;
        if (hif.stall !== 1'b1) begin
            $display("FAIL md_start_stall: stall=%b want 1", hif.stall); failures++;
        end
        step();
        hif.md_start_e = 0; hif.md_is_div_e = 0; #1;
        for (int i = 1; i <= DIV; i++) begin
            checks++;
            if (hif.md_busy !== 1'b1 || hif.stall !== 1'b1) begin
                $display("FAIL md_busy_cycle%0d: busy=%b stall=%b want 1/1",
                         i, hif.md_busy, hif.stall);
                failures++;
            end
            step();
        end
        checks++;
        if (hif.md_busy !== 1'b0 || hif.stall !== 1'b0) begin
            $display("FAIL md_release: busy=%b stall=%b want 0/0", hif.md_busy, hif.stall);
            failures++;
        end
    endtask

    task automatic test_md_reset();
        clear_inputs();
        hif.md_start_e = 1; hif.md_is_div_e = 0; #1;
        step();
        hif.md_start_e = 0; #1;
        step();
        step();
        reset = 1'b1; #1;
        checks++;
        if (hif.md_busy !== 1'b1) begin
            $display("FAIL md_busy_before_reset: busy=%b want 1", hif.md_busy); failures++;
        end
        step();
        reset = 1'b0; #1;
        checks++;
        if (hif.md_busy !== 1'b0 || hif.stall_cnt !== 16'd0) begin
            $display("FAIL md_reset: busy=%b cnt=%0d want 0/0", hif.md_busy, hif.stall_cnt);
            failures++;
        end
    endtask

    task automatic test_dest_zero();
        clear_inputs();
        hif.a3_e = 0; hif.res_e = 2'b01; hif.a1_d = 0; hif.tuse_rs0 = 1;
        hif.a3_m = 0; hif.res_m = 2'b01; hif.a3_w = 0; hif.res_w = 2'b01;
        hif.a1_e = 0; hif.a2_m = 0; #1;
        checks++;
        if (hif.stall !== 1'b0 || hif.fwd_rs_d !== 2'b00 || hif.fwd_rs_e !== 2'b00 ||
            hif.fwd_rt_m !== 1'b0) begin
            $display("FAIL dest_zero: stall=%b fwd_rs_d=%b fwd_rs_e=%b fwd_rt_m=%b want 0/00/00/0",
                     hif.stall, hif.fwd_rs_d, hif.fwd_rs_e, hif.fwd_rt_m);
            failures++;
        end
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            hif.tuse_rs0 = 1'($urandom); hif.tuse_rs1 = 1'($urandom);
            hif.tuse_rt0 = ($urandom_range(0, 3) == 0); hif.tuse_rt1 = 1'($urandom);
            hif.tuse_rt2 = 1'($urandom);
            hif.a1_d = 5'($urandom_range(0, 3)); hif.a2_d = 5'($urandom_range(0, 3));
            hif.a1_e = 5'($urandom_range(0, 3)); hif.a2_e = 5'($urandom_range(0, 3));
            hif.a3_e = 5'($urandom_range(0, 3)); hif.a2_m = 5'($urandom_range(0, 3));
            hif.a3_m = 5'($urandom_range(0, 3)); hif.a3_w = 5'($urandom_range(0, 3));
            hif.res_e = 2'($urandom); hif.res_m = 2'($urandom); hif.res_w = 2'($urandom);
            hif.md_start_e = ($urandom_range(0, 9) == 0);
            hif.md_is_div_e = 1'($urandom);
            hif.md_use_d = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (hif.stall !== model_stall()) begin
                $display("FAIL rnd_stall[%0d]: got %b want %b", i, hif.stall, model_stall());
                failures++;
            end
            checks++;
            if (hif.fwd_rs_d !== model_fwd_d(hif.a1_d) || hif.fwd_rt_d !== model_fwd_d(hif.a2_d)) begin
                $display("FAIL rnd_fwd_d[%0d]: got %b/%b want %b/%b", i, hif.fwd_rs_d,
                         hif.fwd_rt_d, model_fwd_d(hif.a1_d), model_fwd_d(hif.a2_d));
                failures++;
            end
            checks++;
            if (hif.fwd_rs_e !== model_fwd_e(hif.a1_e) || hif.fwd_rt_e !== model_fwd_e(hif.a2_e)) begin
                $display("FAIL rnd_fwd_e[%0d]: got %b/%b want %b/%b", i, hif.fwd_rs_e,
                         hif.fwd_rt_e, model_fwd_e(hif.a1_e), model_fwd_e(hif.a2_e));
                failures++;
            end
            checks++;
            if (hif.fwd_rt_m !== model_fwd_m()) begin
                $display("FAIL rnd_fwd_m[%0d]: got %b want %b", i, hif.fwd_rt_m, model_fwd_m());
                failures++;
            end
            checks++;
            if (hif.md_busy !== (md_rem > 0) || hif.stall_cnt !== 16'(scnt)) begin
                $display("FAIL rnd_state[%0d]: busy=%b cnt=%0d want %b/%0d", i, hif.md_busy,
                         hif.stall_cnt, (md_rem > 0), scnt);
                failures++;
            end
            step();
        end
        reset = 1'b0;
    endtask

    task automatic test_saturate();
        reset = 1'b1;
        clear_inputs();
        step();
        reset = 1'b0;
        hif.res_e = 2'b10; hif.a3_e = 5'd1; hif.a1_d = 5'd1; hif.tuse_rs1 = 1; #1;
        for (int i = 0; i < 65534; i++) step();
        checks++;
        if (hif.stall_cnt !== 16'hFFFE) begin
            $display("FAIL sat_pre: stall_cnt=%h want fffe", hif.stall_cnt); failures++;
        end
        for (int i = 0; i < 70000 - 65534; i++) step();
        checks++;
        if (hif.stall_cnt !== 16'hFFFF || hif.stall_cnt !== 16'(scnt)) begin
            $display("FAIL sat_hold: stall_cnt=%h want ffff (model %0d)", hif.stall_cnt, scnt);
            failures++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        md_rem   = 0;
        scnt     = 0;
        reset    = 1'b1;
        test_reset();
        test_load_use();
        test_branch_fwd();
        test_jal_jr();
        test_store_fwd();
        test_md_timer();
        test_md_reset();
        test_dest_zero();
        test_random();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumes the per-stage decode information produced by the pipeline instruction coder (Tuse flags, register addresses, result class per stage).
- From it, produces the D-stage stall and all forwarding-mux selects for the 5-stage MIPS pipeline.
- Also owns the HI/LO multiply/divide busy timer, which stalls md-class instructions in D, and a saturating stall-cycle counter for performance debug.

Parameters:
- MULT_CYC, 5, busy cycles loaded for mult/multu
- DIV_CYC, 10, busy cycles loaded for div/divu
- CNT_W, 4, width of the md busy counter; must hold DIV_CYC

Ports:
- clk  in  1  clock; one clock, all state on posedge
- reset  in  1  synchronous, active-high
- tuse_rs0, tuse_rs1  in  1 each  rs needed in D / in E
- tuse_rt0, tuse_rt1, tuse_rt2  in  1 each  rt needed in D / E / M
- a1_d, a2_d  in  5 each  D-stage rs/rt
- a1_e, a2_e, a3_e  in  5 each  E-stage rs/rt/dest
- a2_m, a3_m  in  5 each  M-stage rt/dest
- a3_w  in  5  W-stage dest
- res_e, res_m, res_w  in  2 each  result class: 00 none, 01 alu, 10 dm, 11 pc
- md_start_e  in  1  mult/multu/div/divu in E this cycle
- md_is_div_e  in  1  the starting op is div/divu
- md_use_d  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- stall  out  1  freeze PC and IF/ID, bubble ID/EX
- fwd_rs_d, fwd_rt_d  out  2 each  D compare-operand select
- fwd_rs_e, fwd_rt_e  out  2 each  ALU operand select
- fwd_rt_m  out  1  DM write-data select
- md_busy  out  1  HI/LO unit busy
- stall_cnt  out  16  saturating count of stalled cycles

Behaviour:
- Tnew in E: alu=1, dm=2, pc=0, none=0.
- Tnew in M: dm=1, all others 0.
- Tnew in W: 0.
- Tuse for rs: 0 if tuse_rs0, else 1 if tuse_rs1, else unused.
- Tuse for rt: 0 / 1 / 2 from tuse_rt0 / tuse_rt1 / tuse_rt2, else unused.
- Register $0 never matches; any address compare against 0 is false.
- Data stall: for each used source s in {rs,rt}, stall when (a_s==a3_e and Tnew_e>Tuse_s) or (a_s==a3_m and Tnew_m>Tuse_s).
- MD stall: md_use_d and (md_busy or md_start_e).
- stall = data stall OR md stall. Combinational, same cycle.
- Forward codes for D and E selects: 00 register/pipe value, 01 M-stage result (alu or pc8), 10 W-stage result, 11 E-stage pc8.
- Forwarding priority is newest first.
- fwd_x_d:
  - 11 if a==a3_e and res_e==11
  - else 01 if a==a3_m and res_m in {01,11}
  - else 10 if a==a3_w and res_w!=00
  - else 00
- fwd_x_e: 01 if a==a3_m and res_m in {01,11}; else 10 if a==a3_w and res_w!=00; else 00.
- fwd_rt_m: 1 iff a2_m==a3_w, a3_w!=0, res_w!=00.
- A dm result in M is never forwarded to E or D. The stall rule guarantees this is never needed.
- MD counter:
  - md_start_e loads MULT_CYC or DIV_CYC (by md_is_div_e).
  - Otherwise it decrements while nonzero.
  - md_busy = (counter != 0).
  - md_start_e while busy reloads the counter (protocol violation; tolerated, not flagged).
  - The counter keeps running during stall.
- stall_cnt increments every cycle stall=1 and holds at 16'hFFFF.
- Reset:
  - Clears the md counter and stall_cnt, which takes effect the next edge. Reset mid-busy ends busy immediately after that edge.
  - Combinational outputs follow inputs, which the coder drives to 0 on reset, giving stall=0 and all fwd=0.

Test Plan:
- lw $1 in E (res_e=10, a3_e=1); D addu with tuse_rs1, a1_d=1 → stall=1. Next cycle lw in M (res_m=10): stall=0, fwd_rs_e later 10 from W.
- beq with tuse_rs0, a1_d=2; addu in E (res_e=01, a3_e=2) → stall=1. Same addu in M (res_m=01) → stall=0, fwd_rs_d=01.
- jal in E (res_e=11, a3_e=31); jr in D, a1_d=31 → stall=0, fwd_rs_d=11.
- sw with tuse_rt2, a2_d=3; lw a3_e=3 in E → stall=0. Later a2_m=3, a3_w=3, res_w=10 → fwd_rt_m=1.
- md_start_e=1, md_is_div_e=1 → md_busy high for exactly 10 cycles. mflo in D (md_use_d) stalls throughout and is released on cycle 11. Reset asserted at cycle 4 → md_busy=0 after that edge.
- Dest 0: a3_e=0, res_e=01, a1_d=0 with tuse_rs0 → stall=0, fwd=00. Force stall for 70000 cycles → stall_cnt=16'hFFFF, held.
